// File: rtl/lbr_record_unit.sv
// Last-branch-record ring: logs taken transfers, serves age-relative reads and clears.
// Reads return one cycle after the request; no backpressure, stall freezes all state and drops the request.
module lbr_record_unit #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDRESS_BITS = 20,
  parameter int DEPTH        = 8,
  parameter int INDEX_BITS   = 3
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    stall,
  input  logic [1:0]              lbrReq_memory,
  input  logic [1:0]              next_PC_select_memory,
  input  logic [ADDRESS_BITS-1:0] PC_memory,
  input  logic [ADDRESS_BITS-1:0] JAL_target_memory,
  input  logic [ADDRESS_BITS-1:0] JALR_target_memory,
  input  logic [DATA_WIDTH-1:0]   ALU_result_memory,
  output logic [DATA_WIDTH-1:0]   lbr_rdata,
  output logic                    lbr_rvalid,
  output logic [INDEX_BITS:0]     lbr_count,
  output logic                    lbr_overflow
);

  localparam logic [1:0] REQ_RECORD = 2'b01;
  localparam logic [1:0] REQ_READ   = 2'b10;
  localparam logic [1:0] REQ_CLEAR  = 2'b11;

  localparam logic [1:0] SEL_BRANCH = 2'b01;
  localparam logic [1:0] SEL_JAL    = 2'b10;
  localparam logic [1:0] SEL_JALR   = 2'b11;

  localparam logic [INDEX_BITS-1:0] PTR_ONE  = 1;
  localparam logic [INDEX_BITS:0]   CNT_ONE  = 1;
  localparam logic [INDEX_BITS:0]   CNT_FULL = (INDEX_BITS+1)'(DEPTH);

  typedef struct packed {
    logic [ADDRESS_BITS-1:0] from_pc;
    logic [ADDRESS_BITS-1:0] to_pc;
  } lbr_rec_t;

  lbr_rec_t rec_mem [DEPTH];

  logic [INDEX_BITS-1:0]   wr_ptr;
  logic                    taken;
  logic                    rec_we;
  logic [ADDRESS_BITS-1:0] to_addr;
  logic [INDEX_BITS-1:0]   rd_idx;
  logic                    rd_field;
  logic [INDEX_BITS-1:0]   rd_slot;
  logic                    rd_hit;
  logic [ADDRESS_BITS-1:0] rd_addr;
  logic [DATA_WIDTH-1:0]   rdata_next;
  logic                    unused_alu_bits;

  assign unused_alu_bits = ^ALU_result_memory[DATA_WIDTH-1:INDEX_BITS+1];

  always_comb begin
    taken = 1'b0;
    case (next_PC_select_memory)
      SEL_BRANCH: taken = ALU_result_memory[0];
      SEL_JAL:    taken = 1'b1;
      SEL_JALR:   taken = 1'b1;
      default:    taken = 1'b0;
    endcase
  end

  assign to_addr = (next_PC_select_memory == SEL_JALR) ? JALR_target_memory : JAL_target_memory;
  assign rec_we  = !reset && !stall && (lbrReq_memory == REQ_RECORD) && taken;

  // Index 0 is the newest record, i.e. the slot just behind the write pointer.
  assign rd_idx   = ALU_result_memory[INDEX_BITS-1:0];
  assign rd_field = ALU_result_memory[INDEX_BITS];
  assign rd_slot  = wr_ptr - PTR_ONE - rd_idx;
  assign rd_hit   = {1'b0, rd_idx} < lbr_count;

  always_comb begin
    rd_addr    = rd_field ? rec_mem[rd_slot].to_pc : rec_mem[rd_slot].from_pc;
    rdata_next = '0;
    if (rd_hit) begin
      rdata_next = DATA_WIDTH'(rd_addr);
    end
  end

  always_ff @(posedge clock) begin
    if (rec_we) begin
      rec_mem[wr_ptr] <= '{from_pc: PC_memory, to_pc: to_addr};
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr       <= '0;
      lbr_count    <= '0;
      lbr_overflow <= 1'b0;
      lbr_rvalid   <= 1'b0;
      lbr_rdata    <= '0;
    end else begin
      lbr_rvalid <= 1'b0;
      if (!stall) begin
        case (lbrReq_memory)
          REQ_RECORD: begin
            if (taken) begin
              wr_ptr <= wr_ptr + PTR_ONE;
              if (lbr_count == CNT_FULL) begin
                lbr_overflow <= 1'b1;
              end else begin
                lbr_count <= lbr_count + CNT_ONE;
              end
            end
          end
          REQ_READ: begin
            lbr_rvalid <= 1'b1;
            lbr_rdata  <= rdata_next;
          end
          REQ_CLEAR: begin
            wr_ptr       <= '0;
            lbr_count    <= '0;
            lbr_overflow <= 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: doc/lbr_record_unit.md
Name: lbr_record_unit

Overview:
- Memory-stage consumer of the execute-to-memory pipeline register's last-branch-record request field (lbrReq_memory).
- Records taken control transfers as a circular buffer of from-PC / to-target pairs.
- Serves software reads of those records and clear requests, returning read data registered one cycle later for writeback muxing.

Parameters:
DATA_WIDTH, 32, width of ALU_result_memory and read data
ADDRESS_BITS, 20, width of PC and target fields stored per record
DEPTH, 8, number of records; power of two, >= 2
INDEX_BITS, 3, log2(DEPTH)

Ports:
clock  input  1  clock
reset  input  1  synchronous, active-high reset
stall  input  1  pipeline stall; when high all requests are ignored
lbrReq_memory  input  2  00 none, 01 record, 10 read, 11 clear
next_PC_select_memory  input  2  00 PC+4, 01 branch, 10 JAL, 11 JALR
PC_memory  input  ADDRESS_BITS  from-address of the transfer
JAL_target_memory  input  ADDRESS_BITS  branch/JAL target
JALR_target_memory  input  ADDRESS_BITS  JALR target
ALU_result_memory  input  DATA_WIDTH  branch outcome (bit 0) for record; read selector for read
lbr_rdata  output  DATA_WIDTH  read data, zero-extended
lbr_rvalid  output  1  one-cycle pulse, lbr_rdata valid
lbr_count  output  INDEX_BITS+1  valid records, saturates at DEPTH
lbr_overflow  output  1  sticky; a record overwrote the oldest entry

Behaviour:
- Reset (synchronous, active-high, priority over everything):
  - wr_ptr=0, count=0, overflow=0, rvalid=0, rdata=0.
  - Record array contents are don't-care; they are unreadable because count=0.
- Request accepted only when stall=0. With stall=1:
  - no state change; rvalid=0 next cycle; rdata holds.
- Record (01), accepted only if transfer is taken:
  - sel=10 or sel=11: always taken.
  - sel=01: taken iff ALU_result_memory[0]=1.
  - sel=00: never taken; the request is ignored.
  - to-address = JALR_target_memory if sel=11, else JAL_target_memory.
  - Write {PC_memory, to} at wr_ptr; wr_ptr increments mod DEPTH (wrap DEPTH-1 -> 0).
  - If count<DEPTH, count increments; else count stays DEPTH and overflow<=1 (oldest overwritten).
- Read (10):
  - idx = ALU_result_memory[INDEX_BITS-1:0], age-relative: 0 = newest.
  - Field = ALU_result_memory[INDEX_BITS]: 0 from-PC, 1 to-target.
  - Physical slot = (wr_ptr - 1 - idx) mod DEPTH.
  - Next cycle: rvalid=1 and rdata = zero-extended field.
  - If idx >= count: rdata=0, rvalid=1.
  - Latency is 1 cycle. A read issued the cycle after a record sees that record.
- Clear (11): next cycle count=0, wr_ptr=0, overflow=0; rvalid=0.
- Idle (00), or a non-read request: rvalid=0; rdata holds its last value.
- Only one request per cycle by encoding; no simultaneous record/read hazards.
- Upper ALU_result bits above INDEX_BITS are ignored for read.
- lbr_count and lbr_overflow are registered outputs reflecting state after the last accepted request.

Test Plan:
1. Reset, then record JAL (sel=10, PC=0x00100, JAL_target=0x00200); read idx0 field0, then idx0 field1 -> rdata=0x100, then 0x200, each rvalid pulse one cycle after request; count=1.
2. Record with sel=01, ALU_result=0 -> ignored, count unchanged. Same with ALU_result=1 -> recorded. Record with sel=11, JALR_target=0x00ABC -> to-field reads 0x00ABC.
3. Issue 10 records, PC=0x10..0x19 -> count=8, overflow=1; idx0 from=0x19; idx7 from=0x12 (wrap verified).
4. Record PC=0x40 while stall=1 -> count unchanged. Read while stall=1 -> rvalid stays 0.
5. With count=2: read idx5 -> rdata=0, rvalid=1. Then clear -> count=0, overflow=0; read idx0 -> rdata=0.
6. Assert reset mid-sequence after 3 records, in the same cycle as a read request -> next cycle rvalid=0, rdata=0, count=0.
